// File: rtl/pio_pkg.sv
// Shared types and helpers for PIO read/write targets.
// Response encoding, response payload and window decode.
package pio_pkg;

    localparam logic PIO_RESP_OK  = 1'b0;
    localparam logic PIO_RESP_ERR = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } pio_rsp_t;

    // Offset is formed one bit wider than the address so it cannot wrap.
    function automatic logic pio_decode_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] nregs
    );
        logic [32:0] off;
        logic [33:0] lim;
        off = {1'b0, addr} - {1'b0, base};
        lim = {nregs, 2'b00};
        return (addr[1:0] != 2'b00) ||
               (addr < base) ||
               ({1'b0, off} >= lim);
    endfunction

endpackage

// File: rtl/pio_rsp_fifo.sv
// Show-ahead response FIFO for PIO targets.
// Head entry is visible whenever valid is high.
module pio_rsp_fifo
    import pio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  pio_rsp_t      push_data,
    input  logic          pop,
    output pio_rsp_t      head,
    output logic          valid,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pio_rsp_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid  = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign head   = mem[rd_ptr];
    assign do_pop = pop && valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_ovf: assert property (
        @(posedge clk) disable iff (reset) !(push && full)
    );
`endif

endmodule

// File: rtl/pio_rd_target.sv
// PIO read responder: decodes requests, reads the register file
// with fixed latency and returns responses in request order.
module pio_rd_target
    import pio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          NUM_REGS  = 64,
    parameter int          RD_LAT    = 2,
    parameter int          DEPTH     = 4,
    parameter int          AW        = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   addr,
    input  logic          avalid,
    output logic          aready,
    output logic [31:0]   data,
    output logic          dvalid,
    input  logic          dready,
    output logic          resp,
    output logic          reg_rd_en,
    output logic [AW-1:0] reg_rd_addr,
    input  logic [31:0]   reg_rd_data
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]     cnt;
    logic              accept;
    logic              pop;
    logic              err;
    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0] pe;
    pio_rsp_t          push_rsp;
    pio_rsp_t          head;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;

    assign aready      = !reset && (cnt < CW'(DEPTH));
    assign accept      = avalid && aready;
    assign pop         = dvalid && dready;
    assign err         = pio_decode_err(addr, BASE_ADDR, 32'(NUM_REGS));
    assign reg_rd_en   = accept && !err;
    assign reg_rd_addr = AW'((addr - BASE_ADDR) >> 2);

    // Credits cover everything accepted but not yet handed out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv <= '0;
            pe <= '0;
        end else begin
            pv[0] <= accept;
            pe[0] <= err;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
            end
        end
    end

    always_comb begin
        push_rsp      = '0;
        push_rsp.err  = pe[RD_LAT-1];
        push_rsp.data = pe[RD_LAT-1] ? 32'h0 : reg_rd_data;
    end

    pio_rsp_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pv[RD_LAT-1]),
        .push_data (push_rsp),
        .pop       (pop),
        .head      (head),
        .valid     (dvalid),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign data = head.data;
    assign resp = head.err;

`ifndef SYNTHESIS
    a_cnt_max: assert property (
        @(posedge clk) disable iff (reset) cnt <= CW'(DEPTH)
    );
    a_occ: assert property (
        @(posedge clk) disable iff (reset)
        (fifo_count <= cnt) && (!fifo_full || cnt == CW'(DEPTH))
    );
    a_stable: assert property (
        @(posedge clk) disable iff (reset)
        (dvalid && !dready) |=>
        (dvalid && $stable(data) && $stable(resp))
    );
`endif

endmodule
